// File: rtl/ahb_sram_slave.sv
// AHB-Lite single-slave SRAM model: word-organised storage, pipelined address/data
// phases, programmable wait states, byte-lane writes and two-cycle ERROR responses.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   HSEL            slave select
//   HADDR           byte address (address phase)
//   HWRITE          1 = write, 0 = read
//   HSIZE           000 byte, 001 halfword, 010 word
//   HBURST          ignored, bursts handled as individual beats
//   HTRANS          00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//   HMASTLOCK       ignored
//   HWDATA          write data (data phase)
//   HRDATA          read data (full word, master extracts lanes)
//   HREADY          transfer complete; also drives the bus HREADY
//   HRESP           00 OKAY, 01 ERROR
module ahb_sram_slave #(
   parameter int unsigned MEM_AW      = 10,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [2:0]  HBURST,
   input  logic [1:0]  HTRANS,
   input  logic        HMASTLOCK,
   input  logic [31:0] HWDATA,
   output logic [31:0] HRDATA,
   output logic        HREADY,
   output logic [1:0]  HRESP
);

   localparam int unsigned Depth = 2 ** MEM_AW;

   typedef enum logic [1:0] {StIdle, StData, StErr1, StErr2} state_e;

   state_e              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [MEM_AW-1:0]   idx_q, idx_d;
   logic [1:0]          lane_q, lane_d;
   logic [2:0]          size_q, size_d;
   logic                write_q, write_d;

   logic [31:0]         mem [Depth];

   logic                req;
   logic                addr_err;
   logic                can_accept;
   logic                mem_we;
   logic [3:0]          be;

   logic                unused_inputs;
   assign unused_inputs = ^{HBURST, HMASTLOCK};

   assign req = HSEL & HTRANS[1];

   // Any misalignment, oversize or address beyond the array turns the beat into ERROR.
   assign addr_err = (HSIZE > 3'd2)
                   | ((HSIZE == 3'd1) & HADDR[0])
                   | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00))
                   | (HADDR[31:MEM_AW+2] != '0);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      lane_d     = lane_q;
      size_d     = size_q;
      write_d    = write_q;
      HREADY     = 1'b1;
      HRESP      = 2'b00;
      can_accept = 1'b0;

      unique case (state_q)
         StIdle: can_accept = 1'b1;
         StData: begin
            if (cnt_q != 4'd0) begin
               HREADY = 1'b0;
               cnt_d  = cnt_q - 4'd1;
            end else begin
               can_accept = 1'b1;
               state_d    = StIdle;
            end
         end
         StErr1: begin
            HREADY  = 1'b0;
            HRESP   = 2'b01;
            state_d = StErr2;
         end
         StErr2: begin
            HRESP      = 2'b01;
            can_accept = 1'b1;
            state_d    = StIdle;
         end
         default: state_d = StIdle;
      endcase

      if (can_accept && req) begin
         idx_d   = HADDR[MEM_AW+1:2];
         lane_d  = HADDR[1:0];
         size_d  = HSIZE;
         write_d = HWRITE;
         if (addr_err) begin
            state_d = StErr1;
            cnt_d   = 4'd0;
         end else begin
            state_d = StData;
            cnt_d   = 4'(WAIT_STATES);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         idx_q   <= '0;
         lane_q  <= 2'b00;
         size_q  <= 3'b000;
         write_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         lane_q  <= lane_d;
         size_q  <= size_d;
         write_q <= write_d;
      end
   end

   // Lane data is not shifted: lane i always takes HWDATA[8i+7:8i].
   always_comb begin
      case (size_q)
         3'd0:    be = 4'b0001 << lane_q;
         3'd1:    be = 4'b0011 << lane_q;
         default: be = 4'b1111;
      endcase
   end

   // Commit on the edge ending the final data cycle; reset forces StIdle so an
   // interrupted write never reaches this point.
   assign mem_we = (state_q == StData) && (cnt_q == 4'd0) && write_q;

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
         end
      end
   end

   assign HRDATA = ((state_q == StData) && !write_q) ? mem[idx_q] : 32'h0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
module tb_ahb_sram_slave;

   localparam logic [1:0] HtIdle   = 2'b00;
   localparam logic [1:0] HtNonseq = 2'b10;
   localparam logic [2:0] SzByte   = 3'd0;
   localparam logic [2:0] SzHalf   = 3'd1;
   localparam logic [2:0] SzWord   = 3'd2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        hsel_bus = 1'b0;
   logic [31:0] haddr = '0;
   logic        hwrite = 1'b0;
   logic [2:0]  hsize = SzWord;
   logic [1:0]  htrans = HtIdle;
   logic [31:0] hwdata = '0;
   int          sel = 0;

   logic [2:0]  hsel_w;
   logic [2:0]  hready_w;
   logic [1:0]  hresp_w [3];
   logic [31:0] hrdata_w [3];
   logic        hready;
   logic [1:0]  hresp;
   logic [31:0] hrdata;

   int n_checks = 0;
   int n_fail   = 0;
   int lows;

   always #5 clk = ~clk;

   assign hsel_w[0] = hsel_bus && (sel == 0);
   assign hsel_w[1] = hsel_bus && (sel == 1);
   assign hsel_w[2] = hsel_bus && (sel == 2);
   assign hready = hready_w[sel];
   assign hresp  = hresp_w[sel];
   assign hrdata = hrdata_w[sel];

   ahb_sram_slave #(.MEM_AW(10), .WAIT_STATES(0)) u_ws0 (
      .clk(clk), .rst_n(rst_n), .HSEL(hsel_w[0]), .HADDR(haddr), .HWRITE(hwrite),
      .HSIZE(hsize), .HBURST(3'b000), .HTRANS(htrans), .HMASTLOCK(1'b0), .HWDATA(hwdata),
      .HRDATA(hrdata_w[0]), .HREADY(hready_w[0]), .HRESP(hresp_w[0])
   );

   ahb_sram_slave #(.MEM_AW(10), .WAIT_STATES(2)) u_ws2 (
      .clk(clk), .rst_n(rst_n), .HSEL(hsel_w[1]), .HADDR(haddr), .HWRITE(hwrite),
      .HSIZE(hsize), .HBURST(3'b000), .HTRANS(htrans), .HMASTLOCK(1'b0), .HWDATA(hwdata),
      .HRDATA(hrdata_w[1]), .HREADY(hready_w[1]), .HRESP(hresp_w[1])
   );

   ahb_sram_slave #(.MEM_AW(10), .WAIT_STATES(3)) u_ws3 (
      .clk(clk), .rst_n(rst_n), .HSEL(hsel_w[2]), .HADDR(haddr), .HWRITE(hwrite),
      .HSIZE(hsize), .HBURST(3'b000), .HTRANS(htrans), .HMASTLOCK(1'b0), .HWDATA(hwdata),
      .HRDATA(hrdata_w[2]), .HREADY(hready_w[2]), .HRESP(hresp_w[2])
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Drive one cycle's bus signals just after the rising edge, then settle for sampling.
   task automatic drive(input logic hs, input logic [1:0] tr, input logic wr,
                        input logic [2:0] sz, input logic [31:0] ad, input logic [31:0] wd);
      hsel_bus = hs;
      htrans   = tr;
      hwrite   = wr;
      hsize    = sz;
      haddr    = ad;
      hwdata   = wd;
      #2;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Holds the current bus values until HREADY is seen high; reports the low cycles.
   task automatic wait_ready(input int budget, output int n_low);
      n_low = 0;
      while (hready !== 1'b1 && n_low < budget) begin
         next_cycle();
         #2;
         n_low++;
      end
      if (hready !== 1'b1) check_eq("ready_timeout", 32'(hready), 32'd1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #3;
      check_eq("rst_hready", 32'(hready), 32'd1);
      check_eq("rst_hresp", 32'(hresp), 32'd0);
      check_eq("rst_hrdata", hrdata, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      next_cycle();

      // WS=0 write then read, no stalls
      sel = 0;
      drive(1, HtNonseq, 1, SzWord, 32'h10, 32'h0);
      check_eq("t1_wr_addr_ready", 32'(hready), 32'd1);
      next_cycle();
      drive(1, HtNonseq, 0, SzWord, 32'h10, 32'h12345678);
      check_eq("t1_wr_data_ready", 32'(hready), 32'd1);
      next_cycle();
      drive(0, HtIdle, 0, SzWord, 32'h0, 32'h0);
      check_eq("t1_rd_ready", 32'(hready), 32'd1);
      check_eq("t1_rd_data", hrdata, 32'h12345678);
      check_eq("t1_rd_resp", 32'(hresp), 32'd0);
      next_cycle();
      check_eq("t1_idle_rdata", hrdata, 32'h0);

      // Byte and halfword lane writes
      drive(1, HtNonseq, 1, SzWord, 32'h10, 32'h0);
      next_cycle();
      drive(1, HtNonseq, 1, SzByte, 32'h13, 32'h0);
      next_cycle();
      drive(1, HtNonseq, 1, SzHalf, 32'h10, 32'hAB000000);
      next_cycle();
      drive(1, HtNonseq, 0, SzWord, 32'h10, 32'h0000CDEF);
      next_cycle();
      drive(0, HtIdle, 0, SzWord, 32'h0, 32'h0);
      check_eq("t2_lanes", hrdata, 32'hAB00CDEF);
      next_cycle();

      // Pipelined write then read of the same word
      drive(1, HtNonseq, 1, SzWord, 32'h40, 32'h0);
      next_cycle();
      drive(1, HtNonseq, 0, SzWord, 32'h40, 32'hDEADBEEF);
      check_eq("t5_wr_ready", 32'(hready), 32'd1);
      next_cycle();
      drive(0, HtIdle, 0, SzWord, 32'h0, 32'h0);
      check_eq("t5_rd_ready", 32'(hready), 32'd1);
      check_eq("t5_rd_data", hrdata, 32'hDEADBEEF);
      next_cycle();

      // WS=2: wait states and NONSEQ held during wait
      sel = 1;
      drive(1, HtNonseq, 1, SzWord, 32'h20, 32'h0);
      next_cycle();
      drive(1, HtIdle, 0, SzWord, 32'h0, 32'hCAFEF00D);
      wait_ready(20, lows);
      check_eq("t3_wr_waits", 32'(lows), 32'd2);
      drive(1, HtNonseq, 0, SzWord, 32'h20, 32'hCAFEF00D);
      next_cycle();
      drive(1, HtNonseq, 0, SzWord, 32'h24, 32'h0);
      check_eq("t3_rd_stall", 32'(hready), 32'd0);
      wait_ready(20, lows);
      check_eq("t3_rd_waits", 32'(lows), 32'd2);
      check_eq("t3_rd_data", hrdata, 32'hCAFEF00D);
      next_cycle();
      drive(0, HtIdle, 0, SzWord, 32'h0, 32'h0);
      wait_ready(20, lows);
      check_eq("t3_held_waits", 32'(lows), 32'd2);
      next_cycle();

      // Errors: misaligned word, then out-of-range, then OKAY accepted in ERR2
      drive(1, HtNonseq, 1, SzWord, 32'h22, 32'h0);
      next_cycle();
      drive(1, HtIdle, 0, SzWord, 32'h0, 32'hFFFFFFFF);
      check_eq("t4_err1_ready", 32'(hready), 32'd0);
      check_eq("t4_err1_resp", 32'(hresp), 32'd1);
      next_cycle();
      drive(1, HtNonseq, 1, SzWord, 32'h1000, 32'hFFFFFFFF);
      check_eq("t4_err2_ready", 32'(hready), 32'd1);
      check_eq("t4_err2_resp", 32'(hresp), 32'd1);
      next_cycle();
      drive(1, HtIdle, 0, SzWord, 32'h0, 32'hFFFFFFFF);
      check_eq("t4_oor_err1_ready", 32'(hready), 32'd0);
      check_eq("t4_oor_err1_resp", 32'(hresp), 32'd1);
      next_cycle();
      drive(1, HtNonseq, 0, SzWord, 32'h20, 32'hFFFFFFFF);
      check_eq("t4_oor_err2_resp", 32'(hresp), 32'd1);
      next_cycle();
      drive(0, HtIdle, 0, SzWord, 32'h0, 32'h0);
      check_eq("t4_after_resp", 32'(hresp), 32'd0);
      wait_ready(20, lows);
      check_eq("t4_after_waits", 32'(lows), 32'd2);
      check_eq("t4_mem_unchanged", hrdata, 32'hCAFEF00D);
      next_cycle();

      // WS=3: reset during a write wait aborts it
      sel = 2;
      drive(1, HtNonseq, 1, SzWord, 32'h80, 32'h0);
      next_cycle();
      drive(1, HtIdle, 0, SzWord, 32'h0, 32'h11111111);
      wait_ready(20, lows);
      check_eq("t6_old_waits", 32'(lows), 32'd3);
      next_cycle();
      drive(1, HtNonseq, 1, SzWord, 32'h80, 32'h0);
      next_cycle();
      drive(1, HtIdle, 0, SzWord, 32'h0, 32'h22222222);
      check_eq("t6_in_wait", 32'(hready), 32'd0);
      rst_n = 1'b0;
      #1;
      check_eq("t6_rst_ready", 32'(hready), 32'd1);
      check_eq("t6_rst_resp", 32'(hresp), 32'd0);
      check_eq("t6_rst_rdata", hrdata, 32'h0);
      hsel_bus = 1'b0;
      repeat (2) next_cycle();
      rst_n = 1'b1;
      next_cycle();
      drive(1, HtNonseq, 0, SzWord, 32'h80, 32'h0);
      next_cycle();
      drive(0, HtIdle, 0, SzWord, 32'h0, 32'h0);
      wait_ready(20, lows);
      check_eq("t6_rd_waits", 32'(lows), 32'd3);
      check_eq("t6_old_value", hrdata, 32'h11111111);
      next_cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
